// File: rtl/mc_controller.sv
// Multi-cycle main controller: decodes instruction class into datapath selects and
// sequences data-memory requests with an ack watchdog, illegal-encoding trap and stall counter.
module mc_controller #(
  parameter int TIMEOUT_CYCLES = 15,
  parameter int CNT_W          = 16
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             instr_valid,
  input  logic [6:0]       op,
  input  logic [2:0]       instrType,
  input  logic [2:0]       funct3,
  input  logic             mem_ack,
  input  logic             fault_clr,
  output logic             we_reg,
  output logic             pcControl,
  output logic             memory_en,
  output logic             aluBsel,
  output logic             aluAsel,
  output logic             jump,
  output logic             stall,
  output logic [1:0]       wdSelect,
  output logic [1:0]       store_size,
  output logic [1:0]       load_size,
  output logic             load_unsigned,
  output logic             fault,
  output logic [1:0]       fault_cause,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [1:0]       dbg_state
);

  localparam int WD_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam bit WD_EN = (TIMEOUT_CYCLES != 0);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;

  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

  typedef enum logic [1:0] {S_DECODE, S_MEM_WAIT, S_LOAD_WB, S_TRAP} state_t;

  state_t           state_q, state_d;
  logic [WD_W-1:0]  wd_q, wd_d, wd_cur;
  logic             fault_q, fault_d;
  logic [1:0]       cause_q, cause_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             is_store_q, is_store_d;
  logic [1:0]       st_size_q, st_size_d;

  logic       we_c, pc_c, me_c, aa_c, jump_c, stall_c, req_store;
  logic [1:0] wd_sel_c, ss_c;
  logic       ld_f3_ok, st_f3_ok, is_load, is_store, illegal;

  assign ld_f3_ok = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
                    (funct3 == 3'b100) || (funct3 == 3'b101);
  assign st_f3_ok = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
  assign is_load  = (instrType == 3'b100) && (op == OP_LOAD) && ld_f3_ok;
  assign is_store = (instrType == 3'b101) && st_f3_ok;
  assign illegal  = (instrType == 3'b000) || (instrType == 3'b111) ||
                    ((instrType == 3'b100) && (op != OP_LOAD) && (op != OP_IMM) && (op != OP_JALR)) ||
                    ((instrType == 3'b100) && (op == OP_LOAD) && !ld_f3_ok) ||
                    ((instrType == 3'b101) && !st_f3_ok);

  // Memory handshake: memory_en is held with stable store_size/funct3 until a one-cycle
  // mem_ack; mem_ack in any cycle without memory_en is ignored. stall=1 tells upstream to hold.
  always_comb begin
    we_c       = 1'b0;
    pc_c       = 1'b0;
    me_c       = 1'b0;
    aa_c       = 1'b1;
    jump_c     = 1'b0;
    stall_c    = 1'b0;
    wd_sel_c   = 2'b00;
    ss_c       = 2'b11;
    req_store  = 1'b0;
    wd_cur     = '0;
    state_d    = state_q;
    wd_d       = wd_q;
    fault_d    = fault_q;
    cause_d    = cause_q;
    is_store_d = is_store_q;
    st_size_d  = st_size_q;

    case (state_q)
      S_DECODE: begin
        wd_d = '0;
        if (instr_valid) begin
          if (illegal) begin
            stall_c = 1'b1;
            state_d = S_TRAP;
            fault_d = 1'b1;
            cause_d = CAUSE_ILLEGAL;
          end else if (is_load || is_store) begin
            me_c       = 1'b1;
            req_store  = is_store;
            if (is_store) ss_c = funct3[1:0];
            is_store_d = is_store;
            st_size_d  = ss_c;
          end else begin
            case (instrType)
              3'b001: begin
                we_c = 1'b1;
                if (op == OP_AUIPC) aa_c = 1'b0;
                else                wd_sel_c = 2'b11;
              end
              3'b010: begin
                we_c   = 1'b1;
                pc_c   = 1'b1;
                jump_c = 1'b1;
                aa_c   = 1'b0;
              end
              3'b011: begin
                pc_c     = 1'b1;
                wd_sel_c = 2'b10;
              end
              3'b100: begin
                we_c = 1'b1;
                if (op == OP_JALR) begin
                  pc_c     = 1'b1;
                  jump_c   = 1'b1;
                  wd_sel_c = 2'b10;
                  aa_c     = 1'b0;
                end
              end
              3'b110: we_c = !((op == OP_SYSTEM) || (op == OP_FENCE));
              default: ;
            endcase
          end
        end
      end
      S_MEM_WAIT: begin
        me_c      = 1'b1;
        req_store = is_store_q;
        ss_c      = st_size_q;
        wd_cur    = wd_q;
      end
      S_LOAD_WB: begin
        we_c     = 1'b1;
        wd_sel_c = 2'b01;
        state_d  = S_DECODE;
      end
      S_TRAP: begin
        stall_c = 1'b1;
        if (fault_clr) begin
          state_d = S_DECODE;
          fault_d = 1'b0;
          cause_d = 2'b00;
        end
      end
      default: state_d = S_DECODE;
    endcase

    // An ack on the watchdog's final cycle still completes the request.
    if (me_c) begin
      if (mem_ack) begin
        wd_d = '0;
        if (req_store) begin
          stall_c = 1'b0;
          state_d = S_DECODE;
        end else begin
          stall_c = 1'b1;
          state_d = S_LOAD_WB;
        end
      end else begin
        stall_c = 1'b1;
        if (WD_EN && (wd_cur == WD_LAST)) begin
          wd_d    = '0;
          state_d = S_TRAP;
          fault_d = 1'b1;
          cause_d = CAUSE_TIMEOUT;
        end else begin
          wd_d    = wd_cur + 1'b1;
          state_d = S_MEM_WAIT;
        end
      end
    end

    stall_cnt_d = (stall_c && (stall_cnt_q != '1)) ? stall_cnt_q + 1'b1 : stall_cnt_q;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= S_DECODE;
      wd_q        <= '0;
      fault_q     <= 1'b0;
      cause_q     <= 2'b00;
      stall_cnt_q <= '0;
      is_store_q  <= 1'b0;
      st_size_q   <= 2'b11;
    end else begin
      state_q     <= state_d;
      wd_q        <= wd_d;
      fault_q     <= fault_d;
      cause_q     <= cause_d;
      stall_cnt_q <= stall_cnt_d;
      is_store_q  <= is_store_d;
      st_size_q   <= st_size_d;
    end
  end

  // Reset forces defaults at once, even though DECODE would otherwise decode live inputs.
  assign we_reg        = RST_N & we_c;
  assign pcControl     = RST_N & pc_c;
  assign memory_en     = RST_N & me_c;
  assign aluBsel       = 1'b0;
  assign aluAsel       = ~RST_N | aa_c;
  assign jump          = RST_N & jump_c;
  assign stall         = RST_N & stall_c;
  assign wdSelect      = RST_N ? wd_sel_c : 2'b00;
  assign store_size    = RST_N ? ss_c : 2'b11;
  assign load_size     = funct3[1:0];
  assign load_unsigned = funct3[2];
  assign fault         = fault_q;
  assign fault_cause   = cause_q;
  assign stall_cycles  = stall_cnt_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_mc_controller.sv
// Bench for mc_controller: directed scenarios plus randomized transactions checked
// against a transaction-level timing model held in an expected-cycle queue.
module tb_mc_controller;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b1;
  logic        instr_valid = 1'b0;
  logic [6:0]  op = '0;
  logic [2:0]  instrType = '0;
  logic [2:0]  funct3 = '0;
  logic        mem_ack = 1'b0;
  logic        fault_clr = 1'b0;

  logic        we_reg, pcControl, memory_en, aluBsel, aluAsel, jump, stall;
  logic [1:0]  wdSelect, store_size, load_size, fault_cause, dbg_state;
  logic        load_unsigned, fault;
  logic [15:0] stall_cycles;

  logic        we4, pc4, me4, ab4, aa4, j4, st4, lu4, f4;
  logic [1:0]  wd4, ss4, ls4, fc4, ds4;
  logic [3:0]  stall_cycles4;

  logic [10:0] obs;
  assign obs = {we_reg, pcControl, memory_en, aluBsel, aluAsel, jump, stall, wdSelect, store_size};

  mc_controller dut (
    .CLK(CLK), .RST_N(RST_N), .instr_valid(instr_valid), .op(op), .instrType(instrType),
    .funct3(funct3), .mem_ack(mem_ack), .fault_clr(fault_clr),
    .we_reg(we_reg), .pcControl(pcControl), .memory_en(memory_en), .aluBsel(aluBsel),
    .aluAsel(aluAsel), .jump(jump), .stall(stall), .wdSelect(wdSelect), .store_size(store_size),
    .load_size(load_size), .load_unsigned(load_unsigned), .fault(fault), .fault_cause(fault_cause),
    .stall_cycles(stall_cycles), .dbg_state(dbg_state)
  );

  mc_controller #(.TIMEOUT_CYCLES(15), .CNT_W(4)) dut4 (
    .CLK(CLK), .RST_N(RST_N), .instr_valid(instr_valid), .op(op), .instrType(instrType),
    .funct3(funct3), .mem_ack(mem_ack), .fault_clr(fault_clr),
    .we_reg(we4), .pcControl(pc4), .memory_en(me4), .aluBsel(ab4),
    .aluAsel(aa4), .jump(j4), .stall(st4), .wdSelect(wd4), .store_size(ss4),
    .load_size(ls4), .load_unsigned(lu4), .fault(f4), .fault_cause(fc4),
    .stall_cycles(stall_cycles4), .dbg_state(ds4)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [10:0] v;
    logic        f;
    logic [1:0]  c;
    logic        iv;
    logic [2:0]  ty;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        ack;
    logic        clr;
    logic        chk_ls;
  } cyc_t;

  cyc_t exp_q[$];
  int   n_checks = 0;
  int   n_pass = 0;

  // Expected output vector; aluBsel is never asserted by any instruction class.
  function automatic logic [10:0] vec(input logic we, input logic pc, input logic me,
                                      input logic aa, input logic j, input logic st,
                                      input logic [1:0] wd, input logic [1:0] ss);
    return {we, pc, me, 1'b0, aa, j, st, wd, ss};
  endfunction

  function automatic logic [10:0] exp_single(input logic [2:0] ty, input logic [6:0] opc);
    case (ty)
      3'b001:  return (opc == 7'b0010111) ? vec(1, 0, 0, 0, 0, 0, 2'b00, 2'b11)
                                          : vec(1, 0, 0, 1, 0, 0, 2'b11, 2'b11);
      3'b010:  return vec(1, 1, 0, 0, 1, 0, 2'b00, 2'b11);
      3'b011:  return vec(0, 1, 0, 1, 0, 0, 2'b10, 2'b11);
      3'b100:  return (opc == 7'b1100111) ? vec(1, 1, 0, 0, 1, 0, 2'b10, 2'b11)
                                          : vec(1, 0, 0, 1, 0, 0, 2'b00, 2'b11);
      3'b110:  return vec(!((opc == 7'b1110011) || (opc == 7'b0001111)), 0, 0, 1, 0, 0, 2'b00, 2'b11);
      default: return vec(0, 0, 0, 1, 0, 0, 2'b00, 2'b11);
    endcase
  endfunction

  function automatic logic [10:0] def_v();   return vec(0, 0, 0, 1, 0, 0, 2'b00, 2'b11); endfunction
  function automatic logic [10:0] trap_v();  return vec(0, 0, 0, 1, 0, 1, 2'b00, 2'b11); endfunction
  function automatic logic [10:0] load_v();  return vec(0, 0, 1, 1, 0, 1, 2'b00, 2'b11); endfunction
  function automatic logic [10:0] wb_v();    return vec(1, 0, 0, 1, 0, 0, 2'b01, 2'b11); endfunction

  task automatic drive(input logic iv, input logic [2:0] ty, input logic [6:0] opc,
                       input logic [2:0] f3, input logic ack, input logic clr);
    instr_valid = iv; instrType = ty; op = opc; funct3 = f3; mem_ack = ack; fault_clr = clr;
  endtask

  task automatic next_cycle();
    @(posedge CLK); #1;
  endtask

  task automatic reset_dut();
    drive(0, 3'b000, 7'd0, 3'b000, 0, 0);
    RST_N = 1'b0; #2; RST_N = 1'b1;
    next_cycle();
  endtask

  task automatic push(input logic [10:0] v, input logic f, input logic [1:0] c, input logic iv,
                      input logic [2:0] ty, input logic [6:0] opc, input logic [2:0] f3,
                      input logic ack, input logic clr, input logic chk);
    cyc_t e;
    e.v = v; e.f = f; e.c = c; e.iv = iv; e.ty = ty; e.op = opc; e.f3 = f3;
    e.ack = ack; e.clr = clr; e.chk_ls = chk;
    exp_q.push_back(e);
  endtask

  task automatic test_reset();
    @(posedge CLK); #1;
    drive(1, 3'b100, 7'b0010011, 3'b000, 0, 0);
    RST_N = 1'b0;
    @(negedge CLK);
    n_checks++; if (obs !== def_v()) $display("FAIL reset_outputs: got %b want %b", obs, def_v()); else n_pass++;
    n_checks++; if (fault !== 1'b0) $display("FAIL reset_fault: got %b want 0", fault); else n_pass++;
    @(posedge CLK); #1; RST_N = 1'b1;
    @(negedge CLK);
    n_checks++; if (obs !== vec(1, 0, 0, 1, 0, 0, 2'b00, 2'b11)) $display("FAIL addi_outputs: got %b want %b", obs, vec(1, 0, 0, 1, 0, 0, 2'b00, 2'b11)); else n_pass++;
    n_checks++; if (stall_cycles !== 16'd0) $display("FAIL reset_stall_cnt: got %0d want 0", stall_cycles); else n_pass++;
    next_cycle();
    instr_valid = 1'b0;
  endtask

  task automatic test_load();
    reset_dut();
    drive(1, 3'b100, 7'b0000011, 3'b010, 1, 0);
    @(negedge CLK);
    n_checks++; if (obs !== load_v()) $display("FAIL lw0_req: got %b want %b", obs, load_v()); else n_pass++;
    n_checks++; if ({load_size, load_unsigned} !== 3'b100) $display("FAIL lw0_size: got %b want 100", {load_size, load_unsigned}); else n_pass++;
    next_cycle(); mem_ack = 1'b0;
    @(negedge CLK);
    n_checks++; if (obs !== wb_v()) $display("FAIL lw0_wb: got %b want %b", obs, wb_v()); else n_pass++;
    n_checks++; if (stall_cycles !== 16'd1) $display("FAIL lw0_cnt: got %0d want 1", stall_cycles); else n_pass++;
    next_cycle();
    for (int k = 0; k <= 3; k++) begin
      mem_ack = (k == 3);
      @(negedge CLK);
      n_checks++; if (obs !== load_v()) $display("FAIL lw3_req%0d: got %b want %b", k, obs, load_v()); else n_pass++;
      next_cycle();
    end
    mem_ack = 1'b0;
    @(negedge CLK);
    n_checks++; if (obs !== wb_v()) $display("FAIL lw3_wb: got %b want %b", obs, wb_v()); else n_pass++;
    n_checks++; if (stall_cycles !== 16'd5) $display("FAIL lw3_cnt: got %0d want 5", stall_cycles); else n_pass++;
    next_cycle();
    instr_valid = 1'b0;
  endtask

  task automatic test_store();
    reset_dut();
    drive(1, 3'b101, 7'b0100011, 3'b001, 0, 0);
    for (int k = 0; k <= 2; k++) begin
      mem_ack = (k == 2);
      @(negedge CLK);
      n_checks++; if (obs !== vec(0, 0, 1, 1, 0, k < 2, 2'b00, 2'b01)) $display("FAIL sh_cycle%0d: got %b want %b", k, obs, vec(0, 0, 1, 1, 0, k < 2, 2'b00, 2'b01)); else n_pass++;
      next_cycle();
    end
    drive(0, 3'b000, 7'd0, 3'b000, 0, 0);
    @(negedge CLK);
    n_checks++; if (obs !== def_v()) $display("FAIL sh_done: got %b want %b", obs, def_v()); else n_pass++;
    next_cycle();
  endtask

  task automatic test_timeout();
    reset_dut();
    drive(1, 3'b100, 7'b0000011, 3'b000, 0, 0);
    for (int k = 0; k < 15; k++) begin
      @(negedge CLK);
      n_checks++; if (obs !== load_v()) $display("FAIL lb_to_req%0d: got %b want %b", k, obs, load_v()); else n_pass++;
      next_cycle();
    end
    fault_clr = 1'b1;
    @(negedge CLK);
    n_checks++; if (obs !== trap_v()) $display("FAIL lb_to_trap: got %b want %b", obs, trap_v()); else n_pass++;
    n_checks++; if ({fault, fault_cause} !== 3'b110) $display("FAIL lb_to_fault: got %b want 110", {fault, fault_cause}); else n_pass++;
    next_cycle();
    drive(0, 3'b000, 7'd0, 3'b000, 0, 0);
    @(negedge CLK);
    n_checks++; if ({fault, fault_cause} !== 3'b000) $display("FAIL lb_to_clr: got %b want 000", {fault, fault_cause}); else n_pass++;
    n_checks++; if (obs !== def_v()) $display("FAIL lb_to_clr_out: got %b want %b", obs, def_v()); else n_pass++;
    next_cycle();
    drive(1, 3'b100, 7'b0000011, 3'b000, 0, 0);
    for (int k = 0; k < 15; k++) begin
      mem_ack = (k == 14);
      @(negedge CLK);
      n_checks++; if (obs !== load_v()) $display("FAIL lb_last_req%0d: got %b want %b", k, obs, load_v()); else n_pass++;
      next_cycle();
    end
    mem_ack = 1'b0;
    @(negedge CLK);
    n_checks++; if (obs !== wb_v()) $display("FAIL lb_last_wb: got %b want %b", obs, wb_v()); else n_pass++;
    n_checks++; if (fault !== 1'b0) $display("FAIL lb_last_nofault: got %b want 0", fault); else n_pass++;
    next_cycle();
    instr_valid = 1'b0;
  endtask

  task automatic test_illegal();
    reset_dut();
    drive(1, 3'b111, 7'($urandom_range(0, 127)), 3'b000, 0, 1);
    @(negedge CLK);
    n_checks++; if (obs !== trap_v()) $display("FAIL ill_type_cycle: got %b want %b", obs, trap_v()); else n_pass++;
    n_checks++; if (fault !== 1'b0) $display("FAIL ill_type_early: got %b want 0", fault); else n_pass++;
    next_cycle(); fault_clr = 1'b0;
    @(negedge CLK);
    n_checks++; if ({fault, fault_cause} !== 3'b101) $display("FAIL ill_type_trap: got %b want 101", {fault, fault_cause}); else n_pass++;
    fault_clr = 1'b1;
    next_cycle();
    drive(1, 3'b100, 7'b0000011, 3'b011, 0, 0);
    @(negedge CLK);
    n_checks++; if (obs !== trap_v()) $display("FAIL ill_f3_cycle: got %b want %b", obs, trap_v()); else n_pass++;
    n_checks++; if (fault !== 1'b0) $display("FAIL ill_f3_cleared: got %b want 0", fault); else n_pass++;
    next_cycle();
    @(negedge CLK);
    n_checks++; if ({fault, fault_cause} !== 3'b101) $display("FAIL ill_f3_trap: got %b want 101", {fault, fault_cause}); else n_pass++;
    fault_clr = 1'b1;
    next_cycle();
    drive(1, 3'b100, 7'b0000011, 3'b010, 0, 0);
    next_cycle();
    @(negedge CLK);
    n_checks++; if (memory_en !== 1'b1) $display("FAIL rst_pre_mem_en: got %b want 1", memory_en); else n_pass++;
    #1 RST_N = 1'b0;
    #1;
    n_checks++; if (memory_en !== 1'b0) $display("FAIL rst_drop_mem_en: got %b want 0", memory_en); else n_pass++;
    n_checks++; if (obs !== def_v()) $display("FAIL rst_mid_outputs: got %b want %b", obs, def_v()); else n_pass++;
    next_cycle();
    RST_N = 1'b1;
    instr_valid = 1'b0;
    next_cycle();
  endtask

  task automatic test_saturate();
    reset_dut();
    drive(1, 3'b100, 7'b0000011, 3'b100, 0, 0);
    for (int k = 0; k < 20; k++) begin
      @(negedge CLK);
      n_checks++; if (stall_cycles4 !== 4'((k > 15) ? 15 : k)) $display("FAIL sat4_cnt%0d: got %0d want %0d", k, stall_cycles4, (k > 15) ? 15 : k); else n_pass++;
      next_cycle();
    end
    @(negedge CLK);
    n_checks++; if (stall_cycles4 !== 4'd15) $display("FAIL sat4_final: got %0d want 15", stall_cycles4); else n_pass++;
    n_checks++; if (stall_cycles !== 16'd20) $display("FAIL sat16_final: got %0d want 20", stall_cycles); else n_pass++;
    fault_clr = 1'b1;
    next_cycle();
    drive(0, 3'b000, 7'd0, 3'b000, 0, 0);
    next_cycle();
  endtask

  task automatic push_trap(input logic [1:0] cause);
    int n;
    n = $urandom_range(0, 2);
    for (int i = 0; i < n; i++)
      push(trap_v(), 1, cause, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
           7'($urandom_range(0, 127)), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 0, 0);
    push(trap_v(), 1, cause, 0, 3'b000, 7'd0, 3'b000, 1'($urandom_range(0, 1)), 1, 0);
  endtask

  task automatic test_random();
    logic [2:0] ty, f3;
    logic [6:0] opc;
    int cls, lat, sub, cnt;
    logic [2:0] ld_f3[5];
    logic [2:0] bad_ld[3];
    ld_f3 = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    bad_ld = '{3'b011, 3'b110, 3'b111};
    for (int t = 0; t < 200; t++) begin
      cls = $urandom_range(0, 9);
      opc = 7'($urandom_range(0, 127));
      f3  = 3'($urandom_range(0, 7));
      case (cls)
        0, 1, 2, 3, 4, 5: begin
          case (cls)
            0: begin ty = 3'b001; if ($urandom_range(0, 1) == 1) opc = 7'b0010111; end
            1: ty = 3'b010;
            2: ty = 3'b011;
            3: begin ty = 3'b100; opc = 7'b1100111; end
            4: begin ty = 3'b100; opc = 7'b0010011; end
            default: begin
              ty = 3'b110; sub = $urandom_range(0, 3);
              if (sub == 0) opc = 7'b1110011; else if (sub == 1) opc = 7'b0001111;
            end
          endcase
          push(exp_single(ty, opc), 0, 2'b00, 1, ty, opc, f3, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
        end
        6: begin
          ty = 3'b100; opc = 7'b0000011; f3 = ld_f3[$urandom_range(0, 4)];
          if ($urandom_range(0, 7) == 0) begin
            for (int k = 0; k < 15; k++) push(load_v(), 0, 2'b00, 1, ty, opc, f3, 0, 1'($urandom_range(0, 1)), 1);
            push_trap(2'b10);
          end else begin
            lat = $urandom_range(0, 5);
            for (int k = 0; k <= lat; k++) push(load_v(), 0, 2'b00, 1, ty, opc, f3, k == lat, 1'($urandom_range(0, 1)), 1);
            push(wb_v(), 0, 2'b00, 1, ty, opc, f3, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
          end
        end
        7: begin
          ty = 3'b101; f3 = 3'($urandom_range(0, 2)); lat = $urandom_range(0, 5);
          for (int k = 0; k <= lat; k++)
            push(vec(0, 0, 1, 1, 0, k < lat, 2'b00, f3[1:0]), 0, 2'b00, 1, ty, opc, f3, k == lat, 1'($urandom_range(0, 1)), 0);
        end
        8: begin
          sub = $urandom_range(0, 3);
          if (sub == 0) ty = ($urandom_range(0, 1) == 1) ? 3'b111 : 3'b000;
          else if (sub == 1) begin
            ty = 3'b100;
            while (opc == 7'b0000011 || opc == 7'b0010011 || opc == 7'b1100111) opc = 7'($urandom_range(0, 127));
          end else if (sub == 2) begin ty = 3'b100; opc = 7'b0000011; f3 = bad_ld[$urandom_range(0, 2)]; end
          else begin ty = 3'b101; f3 = 3'($urandom_range(3, 7)); end
          push(trap_v(), 0, 2'b00, 1, ty, opc, f3, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
          push_trap(2'b01);
        end
        default: push(def_v(), 0, 2'b00, 0, 3'($urandom_range(0, 7)), opc, f3, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
      endcase
    end

    reset_dut();
    cnt = 0;
    while (exp_q.size() > 0) begin
      cyc_t e;
      e = exp_q.pop_front();
      drive(e.iv, e.ty, e.op, e.f3, e.ack, e.clr);
      @(negedge CLK);
      n_checks++; if (obs !== e.v) $display("FAIL rand_out: got %b want %b (ty %b op %b f3 %b)", obs, e.v, e.ty, e.op, e.f3); else n_pass++;
      n_checks++; if ({fault, fault_cause} !== {e.f, e.c}) $display("FAIL rand_fault: got %b want %b", {fault, fault_cause}, {e.f, e.c}); else n_pass++;
      n_checks++; if (stall_cycles !== 16'(cnt)) $display("FAIL rand_cnt: got %0d want %0d", stall_cycles, cnt); else n_pass++;
      n_checks++; if (stall_cycles4 !== 4'((cnt > 15) ? 15 : cnt)) $display("FAIL rand_cnt4: got %0d want %0d", stall_cycles4, (cnt > 15) ? 15 : cnt); else n_pass++;
      if (e.chk_ls) begin
        n_checks++; if ({load_size, load_unsigned} !== {e.f3[1:0], e.f3[2]}) $display("FAIL rand_ldsize: got %b want %b", {load_size, load_unsigned}, {e.f3[1:0], e.f3[2]}); else n_pass++;
      end
      if (e.v[4]) cnt++;
      next_cycle();
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_store();
    test_timeout();
    test_illegal();
    test_saturate();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
